// File: rtl/jesd_sync_pkg.sv
// jesd_sync_pkg: state encodings and widths shared by the JESD204B RX sync controller.
// Optional SYSREF re-alignment is selected with JESD_SYSREF_REALIGN_EN.
`timescale 1ns/1ps
package jesd_sync_pkg;

  localparam int ST_W   = 3;
  localparam int RCNT_W = 8;

  typedef logic [ST_W-1:0] state_t;

  localparam state_t ST_IDLE        = 3'd0;
  localparam state_t ST_WAIT_SYSREF = 3'd1;
  localparam state_t ST_CGS         = 3'd2;
  localparam state_t ST_WAIT_LMFC   = 3'd3;
  localparam state_t ST_ILAS        = 3'd4;
  localparam state_t ST_DATA        = 3'd5;

  function automatic logic [RCNT_W-1:0] sat_inc(
    input logic [RCNT_W-1:0] v
  );
    return (&v) ? v : v + RCNT_W'(1);
  endfunction

endpackage

// File: rtl/jesd_lmfc_counter.sv
// jesd_lmfc_counter: SYSREF edge detect and LMFC phase counter.
// JESD_SYSREF_REALIGN_EN: every later SYSREF edge re-phases and flags misalignment.
`timescale 1ns/1ps
module jesd_lmfc_counter #(
  parameter int LMFC_CYCLES = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sysref,
  input  logic i_start_en,
  input  logic i_stop,
  output logic o_sysref_edge,
  output logic o_lmfc,
  output logic o_misalign
);

  localparam int CW = (LMFC_CYCLES > 1) ? $clog2(LMFC_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(LMFC_CYCLES - 1);

  logic          r_sysref_d;
  logic          r_run;
  logic [CW-1:0] r_cnt;
  logic          w_edge;
  logic          w_load;
  logic          w_wrap;

  assign w_edge = i_sysref & ~r_sysref_d;
  assign w_wrap = (r_cnt == LAST);

`ifdef JESD_SYSREF_REALIGN_EN
  assign w_load     = w_edge & (i_start_en | r_run);
  assign o_misalign = w_edge & r_run & ~w_wrap;
`else
  assign w_load     = w_edge & i_start_en & ~r_run;
  assign o_misalign = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sysref_d <= 1'b0;
      r_run      <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_sysref_d <= i_sysref;
      if (i_stop) begin
        r_run <= 1'b0;
        r_cnt <= '0;
      end else if (w_load) begin
        r_run <= 1'b1;
        r_cnt <= '0;
      end else if (r_run) begin
        r_cnt <= w_wrap ? '0 : r_cnt + CW'(1);
      end
    end
  end

  assign o_sysref_edge = w_edge;
  assign o_lmfc        = r_run & (r_cnt == '0);

endmodule

// File: rtl/jesd_sync_ctrl.sv
// jesd_sync_ctrl: JESD204B RX link bring-up FSM driving SYNC~ (IDLE..DATA).
// JESD_SYSREF_REALIGN_EN enables SYSREF re-phasing with misalignment resync.
`timescale 1ns/1ps
module jesd_sync_ctrl
  import jesd_sync_pkg::*;
#(
  parameter int LANES           = 4,
  parameter int LMFC_CYCLES     = 8,
  parameter int CGS_MIN         = 4,
  parameter int ILAS_MF         = 4,
  parameter int ILAS_TIMEOUT_MF = 8,
  parameter int ERR_MAX         = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              enable_i,
  input  logic              sysref_i,
  input  logic [LANES-1:0]  lane_k_i,
  input  logic [LANES-1:0]  lane_ilas_i,
  input  logic [LANES-1:0]  lane_err_i,
  output logic              sync_o,
  output logic              lmfc_o,
  output logic              link_up_o,
  output logic [ST_W-1:0]   state_o,
  output logic [RCNT_W-1:0] resync_cnt_o
);

  localparam int KW  = $clog2(CGS_MIN + 1);
  localparam int MFW = $clog2(ILAS_TIMEOUT_MF + 1);
  localparam int EW  = $clog2(ERR_MAX + 1);

  state_t             r_state;
  logic               r_sync;
  logic               r_link_up;
  logic [KW-1:0]      r_kcnt;
  logic [LANES-1:0]   r_flags;
  logic [MFW-1:0]     r_mf;
  logic [EW-1:0]      r_err;
  logic [RCNT_W-1:0]  r_resync_cnt;

  state_t             w_state_nxt;
  logic               w_resync;
  logic               w_lmfc;
  logic               w_edge;
  logic               w_misalign;
  logic               w_kall;
  logic [KW-1:0]      w_k_nxt;
  logic [LANES-1:0]   w_flags_nxt;
  logic               w_flags_all;
  logic [MFW-1:0]     w_mf_nxt;
  logic [EW-1:0]      w_err_nxt;
  logic               w_lmfc_stop;
  logic               w_lmfc_start;

  // Stop the LMFC the same cycle the FSM falls back to IDLE.
  assign w_lmfc_stop  = (r_state == ST_IDLE) | ~enable_i;
  assign w_lmfc_start = (r_state == ST_WAIT_SYSREF);

  jesd_lmfc_counter #(
    .LMFC_CYCLES (LMFC_CYCLES)
  ) u_lmfc (
    .i_clk         (clk_i),
    .i_rst_n       (rst_n_i),
    .i_sysref      (sysref_i),
    .i_start_en    (w_lmfc_start),
    .i_stop        (w_lmfc_stop),
    .o_sysref_edge (w_edge),
    .o_lmfc        (w_lmfc),
    .o_misalign    (w_misalign)
  );

  assign w_kall      = &lane_k_i;
  assign w_k_nxt     = w_kall ? r_kcnt + KW'(1) : '0;
  assign w_flags_nxt = r_flags | lane_ilas_i;
  assign w_flags_all = &w_flags_nxt;
  assign w_mf_nxt    = r_mf + MFW'(1);
  assign w_err_nxt   = r_err + EW'(|lane_err_i);

  always_comb begin
    w_state_nxt = r_state;
    w_resync    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (enable_i) w_state_nxt = ST_WAIT_SYSREF;
      end
      ST_WAIT_SYSREF: begin
        if (w_edge) w_state_nxt = ST_CGS;
      end
      ST_CGS: begin
        if (w_k_nxt == KW'(CGS_MIN)) w_state_nxt = ST_WAIT_LMFC;
      end
      ST_WAIT_LMFC: begin
        if (!w_kall) w_state_nxt = ST_CGS;
        else if (w_lmfc) w_state_nxt = ST_ILAS;
      end
      ST_ILAS: begin
        if (w_misalign) begin
          w_resync = 1'b1;
        end else if (w_lmfc) begin
          if (w_flags_all && w_mf_nxt >= MFW'(ILAS_MF))
            w_state_nxt = ST_DATA;
          else if (!w_flags_all && w_mf_nxt >= MFW'(ILAS_TIMEOUT_MF))
            w_resync = 1'b1;
        end
      end
      ST_DATA: begin
        if (w_misalign || w_err_nxt >= EW'(ERR_MAX)) w_resync = 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_resync) w_state_nxt = ST_CGS;
    // Disable wins over everything and is never counted as a resync.
    if (!enable_i) begin
      w_state_nxt = ST_IDLE;
      w_resync    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state      <= ST_IDLE;
      r_sync       <= 1'b0;
      r_link_up    <= 1'b0;
      r_kcnt       <= '0;
      r_flags      <= '0;
      r_mf         <= '0;
      r_err        <= '0;
      r_resync_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_sync    <= (w_state_nxt == ST_ILAS) | (w_state_nxt == ST_DATA);
      r_link_up <= (w_state_nxt == ST_DATA);
      if (w_resync) r_resync_cnt <= sat_inc(r_resync_cnt);

      if (r_state == ST_CGS && w_state_nxt == ST_CGS) r_kcnt <= w_k_nxt;
      else r_kcnt <= '0;

      if (r_state == ST_ILAS && w_state_nxt == ST_ILAS) begin
        r_flags <= w_flags_nxt;
        if (w_lmfc) r_mf <= w_mf_nxt;
      end else begin
        r_flags <= '0;
        r_mf    <= '0;
      end

      // An error on the boundary cycle is compared before the clear.
      if (r_state == ST_DATA && w_state_nxt == ST_DATA)
        r_err <= w_lmfc ? '0 : w_err_nxt;
      else
        r_err <= '0;
    end
  end

  assign sync_o       = r_sync;
  assign lmfc_o       = w_lmfc;
  assign link_up_o    = r_link_up;
  assign state_o      = r_state;
  assign resync_cnt_o = r_resync_cnt;

endmodule

// File: tb/tb_jesd_sync_ctrl.sv
// tb_jesd_sync_ctrl: directed bench for the JESD204B RX sync controller.
// Expectations follow JESD_SYSREF_REALIGN_EN when the bench is built with it.
`timescale 1ns/1ps
module tb_jesd_sync_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_n_i = 1'b0;
  logic       enable_i = 1'b0;
  logic       sysref_i = 1'b0;
  logic [3:0] lane_k_i = '0;
  logic [3:0] lane_ilas_i = '0;
  logic [3:0] lane_err_i = '0;
  logic       sync_o;
  logic       lmfc_o;
  logic       link_up_o;
  logic [2:0] state_o;
  logic [7:0] resync_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always #5 clk_i = ~clk_i;

  jesd_sync_ctrl dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .enable_i     (enable_i),
    .sysref_i     (sysref_i),
    .lane_k_i     (lane_k_i),
    .lane_ilas_i  (lane_ilas_i),
    .lane_err_i   (lane_err_i),
    .sync_o       (sync_o),
    .lmfc_o       (lmfc_o),
    .link_up_o    (link_up_o),
    .state_o      (state_o),
    .resync_cnt_o (resync_cnt_o)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic step_to(input int t);
    while (cyc < t) step();
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    enable_i = 1'b0;
    sysref_i = 1'b0;
    lane_k_i = '0;
    lane_ilas_i = '0;
    lane_err_i = '0;
    repeat (2) @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    cyc = 0;
  endtask

  // Cycle 0 is the first lmfc_o after the SYSREF edge; ends at cycle 9 in ILAS.
  task automatic to_ilas();
    do_reset();
    enable_i = 1'b1;
    step();
    n_cmp++; if (state_o !== 3'd1) begin n_bad++; $display("FAIL up_wait_sysref: state_o=%0d want 1", state_o); end
    sysref_i = 1'b1;
    step();
    cyc = 0;
    sysref_i = 1'b0;
    n_cmp++; if (state_o !== 3'd2) begin n_bad++; $display("FAIL up_cgs: state_o=%0d want 2", state_o); end
    n_cmp++; if (lmfc_o !== 1'b1) begin n_bad++; $display("FAIL up_first_lmfc: lmfc_o=%0b want 1", lmfc_o); end
    lane_k_i = 4'hF;
    step_to(4);
    n_cmp++; if (state_o !== 3'd3) begin n_bad++; $display("FAIL up_wait_lmfc: state_o=%0d want 3", state_o); end
    n_cmp++; if (sync_o !== 1'b0) begin n_bad++; $display("FAIL up_sync_low: sync_o=%0b want 0", sync_o); end
    step_to(7);
    n_cmp++; if (lmfc_o !== 1'b0) begin n_bad++; $display("FAIL up_lmfc_gap: lmfc_o=%0b want 0", lmfc_o); end
    step_to(8);
    n_cmp++; if (lmfc_o !== 1'b1 || state_o !== 3'd3) begin n_bad++; $display("FAIL up_lmfc8: lmfc_o=%0b state_o=%0d want 1/3", lmfc_o, state_o); end
    step_to(9);
    n_cmp++; if (state_o !== 3'd4 || sync_o !== 1'b1) begin n_bad++; $display("FAIL up_ilas: state_o=%0d sync_o=%0b want 4/1", state_o, sync_o); end
  endtask

  // Ends at cycle 41 in DATA.
  task automatic to_data();
    to_ilas();
    step_to(16);
    lane_ilas_i = 4'hF;
    step_to(17);
    lane_ilas_i = 4'h0;
    step_to(40);
    n_cmp++; if (state_o !== 3'd4 || link_up_o !== 1'b0) begin n_bad++; $display("FAIL up_ilas_hold: state_o=%0d link_up_o=%0b want 4/0", state_o, link_up_o); end
    step_to(41);
    n_cmp++; if (state_o !== 3'd5 || link_up_o !== 1'b1 || sync_o !== 1'b1) begin n_bad++; $display("FAIL up_data: state_o=%0d link_up_o=%0b sync_o=%0b want 5/1/1", state_o, link_up_o, sync_o); end
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    #3;
    n_cmp++; if (state_o !== 3'd0 || sync_o !== 1'b0 || link_up_o !== 1'b0) begin n_bad++; $display("FAIL rst_outputs: state_o=%0d sync_o=%0b link_up_o=%0b want 0/0/0", state_o, sync_o, link_up_o); end
    n_cmp++; if (lmfc_o !== 1'b0 || resync_cnt_o !== 8'd0) begin n_bad++; $display("FAIL rst_lmfc_cnt: lmfc_o=%0b resync_cnt_o=%0d want 0/0", lmfc_o, resync_cnt_o); end
    do_reset();
    sysref_i = 1'b1;
    step_to(3);
    n_cmp++; if (state_o !== 3'd0 || lmfc_o !== 1'b0) begin n_bad++; $display("FAIL idle_hold: state_o=%0d lmfc_o=%0b want 0/0", state_o, lmfc_o); end
    sysref_i = 1'b0;
  endtask

  task automatic test_bring_up();
    to_data();
  endtask

  task automatic test_err_split();
    step_to(46);
    lane_err_i = 4'h1;
    step_to(48);
    lane_err_i = 4'h0;
    n_cmp++; if (lmfc_o !== 1'b1) begin n_bad++; $display("FAIL split_lmfc48: lmfc_o=%0b want 1", lmfc_o); end
    step_to(49);
    lane_err_i = 4'h1;
    step_to(51);
    lane_err_i = 4'h0;
    n_cmp++; if (state_o !== 3'd5 || resync_cnt_o !== 8'd0) begin n_bad++; $display("FAIL split_no_resync: state_o=%0d resync_cnt_o=%0d want 5/0", state_o, resync_cnt_o); end
  endtask

  task automatic test_err_burst();
    step_to(57);
    lane_err_i = 4'h1;
    step_to(60);
    n_cmp++; if (state_o !== 3'd5) begin n_bad++; $display("FAIL burst_pre: state_o=%0d want 5", state_o); end
    step_to(61);
    lane_err_i = 4'h0;
    n_cmp++; if (state_o !== 3'd2 || sync_o !== 1'b0 || link_up_o !== 1'b0) begin n_bad++; $display("FAIL burst_resync: state_o=%0d sync_o=%0b link_up_o=%0b want 2/0/0", state_o, sync_o, link_up_o); end
    n_cmp++; if (resync_cnt_o !== 8'd1) begin n_bad++; $display("FAIL burst_cnt: resync_cnt_o=%0d want 1", resync_cnt_o); end
    step_to(64);
    n_cmp++; if (lmfc_o !== 1'b1 || state_o !== 3'd2) begin n_bad++; $display("FAIL burst_lmfc_runs: lmfc_o=%0b state_o=%0d want 1/2", lmfc_o, state_o); end
    step_to(65);
    n_cmp++; if (state_o !== 3'd3) begin n_bad++; $display("FAIL burst_recgs: state_o=%0d want 3", state_o); end
  endtask

  task automatic test_k_break();
    step_to(66);
    lane_k_i = 4'hE;
    step_to(67);
    lane_k_i = 4'hF;
    n_cmp++; if (state_o !== 3'd2 || sync_o !== 1'b0) begin n_bad++; $display("FAIL kbreak_cgs: state_o=%0d sync_o=%0b want 2/0", state_o, sync_o); end
    step_to(70);
    n_cmp++; if (state_o !== 3'd2) begin n_bad++; $display("FAIL kbreak_restart: state_o=%0d want 2", state_o); end
    step_to(71);
    n_cmp++; if (state_o !== 3'd3) begin n_bad++; $display("FAIL kbreak_wait: state_o=%0d want 3", state_o); end
    step_to(73);
    n_cmp++; if (state_o !== 3'd4 || sync_o !== 1'b1) begin n_bad++; $display("FAIL kbreak_ilas: state_o=%0d sync_o=%0b want 4/1", state_o, sync_o); end
  endtask

  task automatic test_err_boundary();
    to_data();
    step_to(45);
    lane_err_i = 4'h1;
    step_to(48);
    n_cmp++; if (lmfc_o !== 1'b1 || state_o !== 3'd5) begin n_bad++; $display("FAIL bnd_pre: lmfc_o=%0b state_o=%0d want 1/5", lmfc_o, state_o); end
    step_to(49);
    lane_err_i = 4'h0;
    n_cmp++; if (state_o !== 3'd2 || resync_cnt_o !== 8'd1) begin n_bad++; $display("FAIL bnd_resync: state_o=%0d resync_cnt_o=%0d want 2/1", state_o, resync_cnt_o); end
  endtask

  task automatic test_ilas_timeout();
    to_ilas();
    lane_ilas_i = 4'h7;
    step_to(10);
    lane_ilas_i = 4'h0;
    step_to(41);
    n_cmp++; if (state_o !== 3'd4) begin n_bad++; $display("FAIL tmo_no_data: state_o=%0d want 4", state_o); end
    step_to(72);
    n_cmp++; if (state_o !== 3'd4 || sync_o !== 1'b1 || lmfc_o !== 1'b1) begin n_bad++; $display("FAIL tmo_pre: state_o=%0d sync_o=%0b lmfc_o=%0b want 4/1/1", state_o, sync_o, lmfc_o); end
    step_to(73);
    n_cmp++; if (state_o !== 3'd2 || sync_o !== 1'b0) begin n_bad++; $display("FAIL tmo_resync: state_o=%0d sync_o=%0b want 2/0", state_o, sync_o); end
    n_cmp++; if (resync_cnt_o !== 8'd1) begin n_bad++; $display("FAIL tmo_cnt: resync_cnt_o=%0d want 1", resync_cnt_o); end
  endtask

  task automatic test_disable();
    to_data();
    step_to(43);
    enable_i = 1'b0;
    step_to(44);
    n_cmp++; if (state_o !== 3'd0 || sync_o !== 1'b0 || link_up_o !== 1'b0) begin n_bad++; $display("FAIL dis_idle: state_o=%0d sync_o=%0b link_up_o=%0b want 0/0/0", state_o, sync_o, link_up_o); end
    n_cmp++; if (resync_cnt_o !== 8'd0) begin n_bad++; $display("FAIL dis_cnt: resync_cnt_o=%0d want 0", resync_cnt_o); end
    step_to(48);
    n_cmp++; if (lmfc_o !== 1'b0) begin n_bad++; $display("FAIL dis_lmfc_stop: lmfc_o=%0b want 0", lmfc_o); end
  endtask

  task automatic test_sysref_misaligned();
    logic [2:0] exp_st;
    logic       exp_lmfc44;
    logic       exp_lmfc48;
    logic [7:0] exp_cnt;
`ifdef JESD_SYSREF_REALIGN_EN
    exp_st = 3'd2; exp_lmfc44 = 1'b1; exp_lmfc48 = 1'b0; exp_cnt = 8'd1;
`else
    exp_st = 3'd5; exp_lmfc44 = 1'b0; exp_lmfc48 = 1'b1; exp_cnt = 8'd0;
`endif
    to_data();
    step_to(43);
    sysref_i = 1'b1;
    step_to(44);
    sysref_i = 1'b0;
    n_cmp++; if (state_o !== exp_st || resync_cnt_o !== exp_cnt) begin n_bad++; $display("FAIL sref_mis_state: state_o=%0d resync_cnt_o=%0d want %0d/%0d", state_o, resync_cnt_o, exp_st, exp_cnt); end
    n_cmp++; if (lmfc_o !== exp_lmfc44) begin n_bad++; $display("FAIL sref_mis_lmfc44: lmfc_o=%0b want %0b", lmfc_o, exp_lmfc44); end
    step_to(48);
    n_cmp++; if (lmfc_o !== exp_lmfc48) begin n_bad++; $display("FAIL sref_mis_lmfc48: lmfc_o=%0b want %0b", lmfc_o, exp_lmfc48); end
  endtask

  task automatic test_sysref_aligned();
    to_data();
    step_to(47);
    sysref_i = 1'b1;
    step_to(48);
    sysref_i = 1'b0;
    n_cmp++; if (state_o !== 3'd5 || lmfc_o !== 1'b1 || resync_cnt_o !== 8'd0) begin n_bad++; $display("FAIL sref_aligned: state_o=%0d lmfc_o=%0b resync_cnt_o=%0d want 5/1/0", state_o, lmfc_o, resync_cnt_o); end
  endtask

  task automatic test_async_reset();
    to_data();
    #2 rst_n_i = 1'b0;
    #1;
    n_cmp++; if (sync_o !== 1'b0 || link_up_o !== 1'b0 || state_o !== 3'd0 || lmfc_o !== 1'b0) begin n_bad++; $display("FAIL arst: sync_o=%0b link_up_o=%0b state_o=%0d lmfc_o=%0b want 0/0/0/0", sync_o, link_up_o, state_o, lmfc_o); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_bring_up();
    test_err_split();
    test_err_burst();
    test_k_break();
    test_err_boundary();
    test_ilas_timeout();
    test_disable();
    test_sysref_misaligned();
    test_sysref_aligned();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
